alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port round-robin arbiter that time-shares the single 64-bit `ALU` (ALU control plus MIPSALU datapath) of the LEGv8 pipeline between two requesters: the EX stage (port 0) and the branch/address helper (port 1). It accepts at most one operation per cycle and drives the shared ALU's operand and control inputs. It registers the combinational ALU result and `Zero` flag into a per-port one-entry response buffer, with a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 64: operand/result width; must match the shared ALU.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port request accepted this cycle; combinational.
- `req0_aluop`, `req1_aluop`  in  2  ALUOp per port.
- `req0_opcode`, `req1_opcode`  in  11  OpcodeField per port.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_aluop`  out  2  to shared ALU.
- `alu_opcode`  out  11  to shared ALU.
- `alu_a`, `alu_b`  out  WIDTH  to shared ALU.
- `alu_result`  in  WIDTH  from shared ALU, same cycle.
- `alu_zero`  in  1  from shared ALU, same cycle.
- `rsp_valid[1:0]`  out  2  per-port response valid.
- `rsp_ready[1:0]`  in  2  per-port response consumed.
- `rsp0_result`, `rsp1_result`  out  WIDTH  registered result.
- `rsp0_zero`, `rsp1_zero`  out  1  registered Zero flag.

## Operation
- Eligibility: `elig[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i])`. A port whose response buffer is full and not being drained this cycle is never granted.
- Grant:
  - One eligible port: that port wins.
  - Both eligible: the port that did not win most recently wins.
  - The `last_win` register updates only on a grant.
  - `req_ready = grant` (one-hot or zero).
- Mux: ALU inputs carry the granted port's fields. With no grant, they carry port 0's fields, and the result is discarded.
- Response buffer `i`, priority order:
  1. Grant to `i`: load `alu_result`/`alu_zero`, set `rsp_valid[i]`.
  2. Otherwise `rsp_ready[i]` with `rsp_valid[i]` set: clear `rsp_valid[i]`.
  3. Otherwise hold.
- Data is held stable while `rsp_valid` is high and `rsp_ready` is low.
- Simultaneous drain and grant on the same port in the same cycle: the old response is consumed and the new one is loaded. Throughput is one per cycle per port.
- No ALUOp/opcode checking. Undefined encodings pass through; the resulting ALU output is buffered as-is.

## Timing
- Latency: a request accepted in cycle N (`req_valid & req_ready`) gives `rsp_valid` high in cycle N+1.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `last_win`. It must not depend on `alu_result`.
- Requesters hold request fields stable until `req_ready`. `req_valid` may drop without acceptance.
- Reset values (asynchronous on `reset` assertion, including mid-transfer):
  - `rsp_valid = 2'b00`
  - `rsp*_result = 0`
  - `rsp*_zero = 0`
  - `last_win = 1`, so port 0 wins the first contested cycle.
- Any in-flight response is lost on reset. `req_ready` is 0 while `reset` is high.
- Aggregate throughput: one ALU operation per cycle. Under continuous contention with both ports draining, grants alternate 0,1,0,1.

## Structure
- Shared package `alu_arb_pkg`:
  - ALUOp encodings: LDST = 00, BRANCH = x1, RTYPE = 10.
  - R-type opcodes: ADD = 10001011000, SUB = 11001011000, AND = 10001010000, ORR = 10101010000.
  - Port-index constants. The testbench uses the same package.
- Sub-module `rr_arbiter2`: eligibility in, one-hot grant plus `last_win` register. Instantiated once.
- The shared `ALU` instance lives outside this block, at pipeline top level.
- Response buffers are two instances of the same always-block logic (generate loop).

## Test plan
- Port 0 alone: ADD (aluop 10, opcode 10001011000), A=5, B=3, accepted in cycle N -> cycle N+1 `rsp_valid[0]=1`, `rsp0_result=8`, `rsp0_zero=0`.
- Port 1 alone: SUB (opcode 11001011000), A=7, B=7 -> `rsp1_result=0`, `rsp1_zero=1`; port 0 outputs unchanged.
- Both ports valid continuously after reset, `rsp_ready=11` -> grants 0,1,0,1. Each result appears on its own port one cycle after its grant.
- `rsp_ready[0]=0` with `rsp_valid[0]=1` and both requesting -> `req_ready[0]=0` and `rsp0_result` held. Port 1 is granted every cycle. Raising `rsp_ready[0]` re-grants port 0 that same cycle.
- Back-to-back port-0 ORR then AND (A=0xF0, B=0x0F) with `rsp_ready[0]=1` -> responses 0xFF then 0x00 (`zero=1`) on consecutive cycles, no bubble.
- Assert `reset` asynchronously mid-cycle with `rsp_valid=11` -> all outputs 0 immediately. After release, a contested request grants port 0 first.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the LEGv8 ALU-sharing arbiter: ALUOp/opcode encodings,
// port indices and the ALU control payload.
package alu_arb_pkg;

  localparam int unsigned ALUOP_W     = 2;
  localparam int unsigned OPCODE_W    = 11;
  localparam int unsigned NUM_PORTS   = 2;
  localparam int unsigned PORT_EX     = 0;
  localparam int unsigned PORT_HELPER = 1;

  localparam logic [ALUOP_W-1:0] ALUOP_LDST   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [OPCODE_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OPC_ORR = 11'b10101010000;

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [OPCODE_W-1:0] opcode;
  } alu_ctrl_t;

  // BRANCH is encoded as x1, so only the low ALUOp bit matters
  function automatic logic is_branch(input logic [ALUOP_W-1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant from eligibility,
// with a last-winner register that flips priority after each grant.
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] i_elig,
  output logic [NUM_PORTS-1:0] o_grant_c
);

  logic r_last_win;

  // Contested cycles go to the port that did not win last; nothing is granted in reset
  always_comb begin
    o_grant_c = '0;
    if (!reset) begin
      case (i_elig)
        2'b01:   o_grant_c = 2'b01;
        2'b10:   o_grant_c = 2'b10;
        2'b11:   o_grant_c = r_last_win ? 2'b01 : 2'b10;
        default: o_grant_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_win <= 1'b1;
    end else if (|o_grant_c) begin
      r_last_win <= o_grant_c[PORT_HELPER];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares the pipeline's single ALU between the EX stage (port 0) and the
// branch/address helper (port 1), buffering one registered response per port.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [ALUOP_W-1:0]   req0_aluop,
  input  logic [ALUOP_W-1:0]   req1_aluop,
  input  logic [OPCODE_W-1:0]  req0_opcode,
  input  logic [OPCODE_W-1:0]  req1_opcode,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic [ALUOP_W-1:0]   alu_aluop,
  output logic [OPCODE_W-1:0]  alu_opcode,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  output logic [NUM_PORTS-1:0] rsp_valid,
  input  logic [NUM_PORTS-1:0] rsp_ready,
  output logic [WIDTH-1:0]     rsp0_result,
  output logic [WIDTH-1:0]     rsp1_result,
  output logic                 rsp0_zero,
  output logic                 rsp1_zero
);

  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] w_rsp_valid;
  alu_ctrl_t            w_ctrl;

  logic             r_rsp_valid  [NUM_PORTS];
  logic [WIDTH-1:0] r_rsp_result [NUM_PORTS];
  logic             r_rsp_zero   [NUM_PORTS];

  always_comb begin
    w_rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_rsp_valid[i] = r_rsp_valid[i];
    end
  end

  // A full buffer may still accept when it is being drained in the same cycle
  assign w_elig = req_valid & (~w_rsp_valid | rsp_ready);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_elig    (w_elig),
    .o_grant_c (w_grant)
  );

  assign req_ready = w_grant;

  // Port 0 drives the ALU by default; its result is simply dropped when ungranted
  always_comb begin
    w_ctrl = '{aluop: req0_aluop, opcode: req0_opcode};
    alu_a  = req0_a;
    alu_b  = req0_b;
    if (w_grant[PORT_HELPER]) begin
      w_ctrl = '{aluop: req1_aluop, opcode: req1_opcode};
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  assign alu_aluop  = w_ctrl.aluop;
  assign alu_opcode = w_ctrl.opcode;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
    // Load on grant takes precedence over drain, giving one response per cycle per port
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rsp_valid[gi]  <= 1'b0;
        r_rsp_result[gi] <= '0;
        r_rsp_zero[gi]   <= 1'b0;
      end else if (w_grant[gi]) begin
        r_rsp_valid[gi]  <= 1'b1;
        r_rsp_result[gi] <= alu_result;
        r_rsp_zero[gi]   <= alu_zero;
      end else if (rsp_ready[gi] && r_rsp_valid[gi]) begin
        r_rsp_valid[gi]  <= 1'b0;
      end
    end
  end

  assign rsp_valid   = w_rsp_valid;
  assign rsp0_result = r_rsp_result[PORT_EX];
  assign rsp1_result = r_rsp_result[PORT_HELPER];
  assign rsp0_zero   = r_rsp_zero[PORT_EX];
  assign rsp1_zero   = r_rsp_zero[PORT_HELPER];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push expected
// responses; a negedge monitor compares every presented response.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned W = 64;

  typedef struct packed {
    alu_ctrl_t    ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           due;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_ready;
  req_t                 d0, d1;
  logic [ALUOP_W-1:0]   alu_aluop;
  logic [OPCODE_W-1:0]  alu_opcode;
  logic [W-1:0]         alu_a, alu_b, alu_result;
  logic                 alu_zero;
  logic [NUM_PORTS-1:0] rsp_valid;
  logic [NUM_PORTS-1:0] rsp_ready;
  logic [W-1:0]         rsp0_result, rsp1_result;
  logic                 rsp0_zero, rsp1_zero;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   sn       = 0;

  localparam req_t Z = '0;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_aluop  (d0.ctrl.aluop),
    .req1_aluop  (d1.ctrl.aluop),
    .req0_opcode (d0.ctrl.opcode),
    .req1_opcode (d1.ctrl.opcode),
    .req0_a      (d0.a),
    .req0_b      (d0.b),
    .req1_a      (d1.a),
    .req1_b      (d1.b),
    .alu_aluop   (alu_aluop),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp0_result (rsp0_result),
    .rsp1_result (rsp1_result),
    .rsp0_zero   (rsp0_zero),
    .rsp1_zero   (rsp1_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared LEGv8 ALU at pipeline top level
  always_comb begin
    alu_result = '0;
    if (alu_aluop == ALUOP_LDST) alu_result = alu_a + alu_b;
    else if (is_branch(alu_aluop)) alu_result = alu_b;
    else begin
      case (alu_opcode)
        OPC_ADD: alu_result = alu_a + alu_b;
        OPC_SUB: alu_result = alu_a - alu_b;
        OPC_AND: alu_result = alu_a & alu_b;
        OPC_ORR: alu_result = alu_a | alu_b;
        default: alu_result = '0;
      endcase
    end
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic req_t mk(input logic [ALUOP_W-1:0] op, input logic [OPCODE_W-1:0] opc,
                              input logic [W-1:0] a, input logic [W-1:0] b);
    req_t r;
    r.ctrl.aluop  = op;
    r.ctrl.opcode = opc;
    r.a = a;
    r.b = b;
    return r;
  endfunction

  task automatic pop(input int p);
    if (p == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  // One cycle of stimulus; the grant check happens before the clock edge
  task automatic step(input logic [1:0] v, input logic [1:0] rr, input req_t r0, input req_t r1,
                      input logic [1:0] er, input logic [W-1:0] e0, input logic z0,
                      input logic [W-1:0] e1, input logic z1);
    exp_t e;
    @(negedge clk);
    sn++;
    d0 = r0;
    d1 = r1;
    req_valid = v;
    rsp_ready = rr;
    #1;
    chk($sformatf("req_ready_s%0d", sn), W'(req_ready), W'(er));
    if (req_ready[0]) begin
      e.res = e0; e.zero = z0; e.due = cyc + 1;
      q0.push_back(e);
    end
    if (req_ready[1]) begin
      e.res = e1; e.zero = z1; e.due = cyc + 1;
      q1.push_back(e);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic rr, input logic [W-1:0] res, input logic z);
    exp_t e;
    int   sz;
    sz = (p == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      if (p == 0) e = q0[0];
      else        e = q1[0];
    end
    if (v) begin
      if (sz == 0) chk($sformatf("rsp%0d_valid_unexpected", p), W'(v), W'(0));
      else begin
        chk($sformatf("rsp%0d_result", p), res, e.res);
        chk($sformatf("rsp%0d_zero", p), W'(z), W'(e.zero));
        if (rr) pop(p);
      end
    end else if (sz > 0 && e.due <= cyc) begin
      chk($sformatf("rsp%0d_valid_late", p), W'(v), W'(1));
      pop(p);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      mon(0, rsp_valid[0], rsp_ready[0], rsp0_result, rsp0_zero);
      mon(1, rsp_valid[1], rsp_ready[1], rsp1_result, rsp1_zero);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    d0 = Z;
    d1 = Z;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp_valid", W'(rsp_valid), W'(0));
    chk("reset_rsp0_result", rsp0_result, W'(0));
    chk("reset_rsp1_result", rsp1_result, W'(0));
    chk("reset_req_ready", W'(req_ready), W'(0));
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;

    // Single-port requests
    step(2'b01, 2'b00, mk(ALUOP_RTYPE, OPC_ADD, 64'd5, 64'd3), Z, 2'b01, 64'd8, 1'b0, 64'd0, 1'b0);
    step(2'b00, 2'b11, Z, Z, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
    step(2'b10, 2'b11, Z, mk(ALUOP_RTYPE, OPC_SUB, 64'd7, 64'd7), 2'b10, 64'd0, 1'b0, 64'd0, 1'b1);
    step(2'b00, 2'b11, Z, Z, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
    chk("rsp0_result_untouched", rsp0_result, 64'd8);

    // Continuous contention, both draining: 0,1,0,1
    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd10, 64'd20), mk(ALUOP_RTYPE, OPC_SUB, 64'd100, 64'd1),
         2'b01, 64'd30, 1'b0, 64'd0, 1'b0);
    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd11, 64'd20), mk(ALUOP_RTYPE, OPC_SUB, 64'd100, 64'd1),
         2'b10, 64'd0, 1'b0, 64'd99, 1'b0);
    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd11, 64'd20), mk(ALUOP_RTYPE, OPC_SUB, 64'd50, 64'd60),
         2'b01, 64'd31, 1'b0, 64'd0, 1'b0);
    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd2, 64'd2), mk(ALUOP_RTYPE, OPC_SUB, 64'd50, 64'd60),
         2'b10, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd2, 64'd2), mk(ALUOP_RTYPE, OPC_SUB, 64'd9, 64'd4),
         2'b01, 64'd4, 1'b0, 64'd0, 1'b0);

    // Port 0 back-pressured: port 1 takes every cycle, then port 0 re-granted on drain
    step(2'b11, 2'b10, mk(ALUOP_RTYPE, OPC_ADD, 64'd6, 64'd6), mk(ALUOP_RTYPE, OPC_SUB, 64'd9, 64'd4),
         2'b10, 64'd0, 1'b0, 64'd5, 1'b0);
    step(2'b11, 2'b10, mk(ALUOP_RTYPE, OPC_ADD, 64'd6, 64'd6), mk(ALUOP_RTYPE, OPC_ADD, 64'd1, 64'd1),
         2'b10, 64'd0, 1'b0, 64'd2, 1'b0);
    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd6, 64'd6), mk(ALUOP_RTYPE, OPC_SUB, 64'd3, 64'd3),
         2'b01, 64'd12, 1'b0, 64'd0, 1'b0);
    step(2'b10, 2'b11, Z, mk(ALUOP_RTYPE, OPC_SUB, 64'd3, 64'd3), 2'b10, 64'd0, 1'b0, 64'd0, 1'b1);

    // Back-to-back on port 0 with no bubble
    step(2'b01, 2'b11, mk(ALUOP_RTYPE, OPC_ORR, 64'hF0, 64'h0F), Z, 2'b01, 64'hFF, 1'b0, 64'd0, 1'b0);
    step(2'b01, 2'b11, mk(ALUOP_RTYPE, OPC_AND, 64'hF0, 64'h0F), Z, 2'b01, 64'h00, 1'b1, 64'd0, 1'b0);
    step(2'b00, 2'b11, Z, Z, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);

    // Fill both buffers (LDST add, BRANCH with an undefined opcode passing B)
    step(2'b11, 2'b00, mk(ALUOP_LDST, 11'd0, 64'd1, 64'd1), mk(2'b11, 11'h7FF, 64'd9, 64'd4),
         2'b10, 64'd0, 1'b0, 64'd4, 1'b0);
    step(2'b11, 2'b00, mk(ALUOP_LDST, 11'd0, 64'd1, 64'd1), mk(ALUOP_RTYPE, OPC_ADD, 64'd1, 64'd1),
         2'b01, 64'd2, 1'b0, 64'd0, 1'b0);
    step(2'b11, 2'b00, mk(ALUOP_RTYPE, OPC_ADD, 64'd1, 64'd1), mk(ALUOP_RTYPE, OPC_ADD, 64'd1, 64'd1),
         2'b00, 64'd0, 1'b0, 64'd0, 1'b0);

    // Asynchronous reset mid-cycle with both responses pending
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", W'(rsp_valid), W'(0));
    chk("midreset_rsp0_result", rsp0_result, W'(0));
    chk("midreset_rsp1_result", rsp1_result, W'(0));
    chk("midreset_rsp0_zero", W'(rsp0_zero), W'(0));
    chk("midreset_rsp1_zero", W'(rsp1_zero), W'(0));
    chk("midreset_req_ready", W'(req_ready), W'(0));
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;

    step(2'b11, 2'b11, mk(ALUOP_RTYPE, OPC_ADD, 64'd7, 64'd8), mk(ALUOP_RTYPE, OPC_ADD, 64'd1, 64'd0),
         2'b01, 64'd15, 1'b0, 64'd0, 1'b0);
    step(2'b00, 2'b11, Z, Z, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
    step(2'b00, 2'b11, Z, Z, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    #3;
    chk("q0_drained", W'(q0.size()), W'(0));
    chk("q1_drained", W'(q1.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
